// File: rtl/msj_setpoint_manager.sv
// Setpoint manager for a multi-motor rig: Avalon-MM register file, debounced
// front-panel buttons that nudge per-motor targets, and a slew-limited ramp
// from target to setpoint on every control tick.
//
// Ports:
//   clock, reset        - single clock, synchronous active-high reset
//   address[15:8]       - register select, address[7:0] motor index
//   write/writedata     - zero-wait-state register writes
//   read/readdata       - reads with exactly one wait cycle (waitrequest)
//   update_tick         - control-cycle strobe, advances the ramp
//   pull_buttons,
//   release_buttons     - active-low per-motor nudge buttons (asynchronous)
//   zero_pose_button    - active-low, forces every target to clamped zero
//   release_all_button  - active-low, lowers every target by its step
//   sp                  - packed ramped setpoints, motor k at [32k+31:32k]
//   sp_strobe           - one-cycle pulse following each update_tick
//   at_target           - per-motor sp == target, registered
//   mute                - registered copy of ctrl bit1
module msj_setpoint_manager #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int SP_RESET_MIN     = -4096,
    parameter int SP_RESET_MAX     = 4095
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [15:0]                    address,
    input  logic                           write,
    input  logic signed [31:0]             writedata,
    input  logic                           read,
    output logic [31:0]                    readdata,
    output logic                           waitrequest,
    input  logic                           update_tick,
    input  logic [NUMBER_OF_MOTORS-1:0]    pull_buttons,
    input  logic [NUMBER_OF_MOTORS-1:0]    release_buttons,
    input  logic                           zero_pose_button,
    input  logic                           release_all_button,
    output logic [32*NUMBER_OF_MOTORS-1:0] sp,
    output logic                           sp_strobe,
    output logic [NUMBER_OF_MOTORS-1:0]    at_target,
    output logic                           mute
);

    localparam int N    = NUMBER_OF_MOTORS;
    localparam int NB   = 2 * N + 2;
    localparam int ZP   = 2 * N;
    localparam int RA   = 2 * N + 1;
    localparam int AT_W = (N < 32) ? N : 32;

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    localparam logic [7:0] SEL_TARGET = 8'h00;
    localparam logic [7:0] SEL_SP     = 8'h01;
    localparam logic [7:0] SEL_SLEW   = 8'h02;
    localparam logic [7:0] SEL_MIN    = 8'h03;
    localparam logic [7:0] SEL_MAX    = 8'h04;
    localparam logic [7:0] SEL_BSTEP  = 8'h05;
    localparam logic [7:0] SEL_CTRL   = 8'h06;
    localparam logic [7:0] SEL_AT     = 8'h07;

    // ------------------------------------------------------------------
    // Button synchronisers and debouncers
    // ------------------------------------------------------------------
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_meta;
    logic [NB-1:0] btn_sync;
    logic [NB-1:0] btn_deb;
    logic [23:0]   db_cnt [NB];
    // Previous debounced level of every edge-triggered button
    // (zero_pose is level-sensitive and needs no history).
    logic [2*N:0]  btn_prev;

    assign btn_raw = {release_all_button, zero_pose_button,
                      release_buttons, pull_buttons};

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta <= '1;
            btn_sync <= '1;
            btn_deb  <= '1;
            btn_prev <= '1;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            btn_prev <= {btn_deb[RA], btn_deb[2*N-1:0]};
            for (int i = 0; i < NB; i++) begin
                // Counter measures how long the synchronised level has
                // disagreed with the accepted level; any agreement restarts it.
                if (btn_sync[i] == btn_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_deb[i] <= btn_sync[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 24'd1;
                end
            end
        end
    end

    logic [N-1:0] pull_fall;
    logic [N-1:0] rel_fall;
    logic         ra_fall;
    logic         zero_act;

    assign pull_fall = btn_prev[N-1:0]   & ~btn_deb[N-1:0];
    assign rel_fall  = btn_prev[2*N-1:N] & ~btn_deb[2*N-1:N];
    assign ra_fall   = btn_prev[2*N]     & ~btn_deb[RA];
    assign zero_act  = ~btn_deb[ZP];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic signed [31:0] target_q [N];
    logic signed [31:0] sp_q     [N];
    logic [30:0]        slew_q   [N];
    logic signed [31:0] min_q    [N];
    logic signed [31:0] max_q    [N];
    logic [31:0]        bstep_q  [N];
    logic               hold_q;
    logic               mute_bit_q;
    logic [N-1:0]       at_target_q;
    logic               rd_done;

    logic [7:0] sel;
    logic [7:0] idx;
    logic       idx_ok;

    assign sel    = address[15:8];
    assign idx    = address[7:0];
    assign idx_ok = 32'(idx) < 32'(N);

    // Clamp a widened intermediate into [lo, hi]. Results are formed at
    // 34 bits so that target +/- a full 32-bit unsigned step cannot wrap.
    function automatic logic signed [31:0] clamp_wide(
        input logic signed [33:0] v,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        logic signed [33:0] lo_x;
        logic signed [33:0] hi_x;
        lo_x = 34'(lo);
        hi_x = 34'(hi);
        if (v < lo_x) begin
            return lo;
        end else if (v > hi_x) begin
            return hi;
        end else begin
            return v[31:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Next target (priority: zero pose, bus write, release-all, buttons)
    // and next ramped setpoint
    // ------------------------------------------------------------------
    logic [N-1:0]       wr_motor;
    logic signed [31:0] lim_lo    [N];
    logic signed [31:0] lim_hi    [N];
    logic signed [33:0] step_s    [N];
    logic signed [33:0] tgt_base  [N];
    logic signed [31:0] tgt_nxt   [N];
    logic signed [32:0] ramp_d    [N];
    logic [32:0]        ramp_mag  [N];
    logic [32:0]        ramp_slew [N];
    logic signed [31:0] sp_nxt    [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            wr_motor[k] = write && (idx == 8'(k));

            // A limit written this cycle already governs this cycle's
            // target, so the target never leaves the new window.
            lim_lo[k] = (wr_motor[k] && sel == SEL_MIN) ? writedata : min_q[k];
            lim_hi[k] = (wr_motor[k] && sel == SEL_MAX) ? writedata : max_q[k];

            step_s[k] = {2'b00, bstep_q[k]};

            if (zero_act) begin
                tgt_base[k] = '0;
            end else if (wr_motor[k] && sel == SEL_TARGET) begin
                tgt_base[k] = 34'(writedata);
            end else if (ra_fall) begin
                tgt_base[k] = 34'(target_q[k]) - step_s[k];
            end else begin
                tgt_base[k] = 34'(target_q[k]);
                if (pull_fall[k]) begin
                    tgt_base[k] = tgt_base[k] + step_s[k];
                end
                if (rel_fall[k]) begin
                    tgt_base[k] = tgt_base[k] - step_s[k];
                end
            end
            tgt_nxt[k] = clamp_wide(tgt_base[k], lim_lo[k], lim_hi[k]);

            ramp_d[k]    = 33'(target_q[k]) - 33'(sp_q[k]);
            ramp_mag[k]  = ramp_d[k][32] ? 33'(-ramp_d[k]) : 33'(ramp_d[k]);
            ramp_slew[k] = {2'b00, slew_q[k]};

            if (!update_tick || hold_q) begin
                sp_nxt[k] = sp_q[k];
            end else if (slew_q[k] == '0 || ramp_mag[k] <= ramp_slew[k]) begin
                sp_nxt[k] = target_q[k];
            end else if (ramp_d[k][32]) begin
                sp_nxt[k] = sp_q[k] - signed'({1'b0, slew_q[k]});
            end else begin
                sp_nxt[k] = sp_q[k] + signed'({1'b0, slew_q[k]});
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] rd_tgt;
    logic [31:0] rd_sp;
    logic [31:0] rd_slew;
    logic [31:0] rd_min;
    logic [31:0] rd_max;
    logic [31:0] rd_bstep;
    logic [31:0] rd_at;
    logic [31:0] rd_val;

    always_comb begin
        rd_tgt   = '0;
        rd_sp    = '0;
        rd_slew  = '0;
        rd_min   = '0;
        rd_max   = '0;
        rd_bstep = '0;
        rd_at    = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == 8'(k)) begin
                rd_tgt   = target_q[k];
                rd_sp    = sp_q[k];
                rd_slew  = {1'b0, slew_q[k]};
                rd_min   = min_q[k];
                rd_max   = max_q[k];
                rd_bstep = bstep_q[k];
            end
        end
        for (int k = 0; k < AT_W; k++) begin
            rd_at[k] = at_target_q[k];
        end

        rd_val = 32'hDEADBEEF;
        case (sel)
            SEL_TARGET: if (idx_ok) rd_val = rd_tgt;
            SEL_SP:     if (idx_ok) rd_val = rd_sp;
            SEL_SLEW:   if (idx_ok) rd_val = rd_slew;
            SEL_MIN:    if (idx_ok) rd_val = rd_min;
            SEL_MAX:    if (idx_ok) rd_val = rd_max;
            SEL_BSTEP:  if (idx_ok) rd_val = rd_bstep;
            SEL_CTRL:   rd_val = {30'd0, mute_bit_q, hold_q};
            SEL_AT:     rd_val = rd_at;
            default:    rd_val = 32'hDEADBEEF;
        endcase
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                target_q[k] <= '0;
                sp_q[k]     <= '0;
                slew_q[k]   <= 31'd16;
                min_q[k]    <= SP_RESET_MIN;
                max_q[k]    <= SP_RESET_MAX;
                bstep_q[k]  <= 32'd10;
            end
            hold_q      <= 1'b0;
            mute_bit_q  <= 1'b0;
            mute        <= 1'b0;
            sp_strobe   <= 1'b0;
            at_target_q <= '1;
            readdata    <= '0;
            rd_done     <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                target_q[k]    <= tgt_nxt[k];
                sp_q[k]        <= sp_nxt[k];
                at_target_q[k] <= (sp_q[k] == target_q[k]);
                if (wr_motor[k]) begin
                    case (sel)
                        SEL_SLEW:  slew_q[k]  <= writedata[30:0];
                        SEL_MIN:   min_q[k]   <= writedata;
                        SEL_MAX:   max_q[k]   <= writedata;
                        SEL_BSTEP: bstep_q[k] <= writedata;
                        default:   ;
                    endcase
                end
            end
            if (write && sel == SEL_CTRL) begin
                hold_q     <= writedata[0];
                mute_bit_q <= writedata[1];
            end
            mute      <= mute_bit_q;
            sp_strobe <= update_tick;
            if (read && !rd_done) begin
                readdata <= rd_val;
                rd_done  <= 1'b1;
            end else if (!read) begin
                rd_done <= 1'b0;
            end
        end
    end

    assign waitrequest = read && !rd_done;
    assign at_target   = at_target_q;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            sp[32*k +: 32] = sp_q[k];
        end
    end

endmodule
